banked_byte_ram: RTL and testbench

BANKED_BYTE_RAM -- requirements
Module: banked_byte_ram

---
 rtl/banked_byte_ram_if.sv | 24 ++
 rtl/banked_byte_ram.sv | 181 ++++++++++++++++++
 tb/tb_banked_byte_ram.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/banked_byte_ram_if.sv
// Request/response bus of banked_byte_ram: a ready/valid request channel and a
// one-cycle response pulse carrying load data and an error flag.
interface banked_byte_ram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_mode;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_mode, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_mode, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/banked_byte_ram.sv
// Byte-addressable RAM built from four byte-wide banks; byte/halfword/word loads and stores.
// Define BANKED_BYTE_RAM_MISALIGN_SPLIT_EN to run word-crossing accesses as two beats (else they error).
module banked_byte_ram #(
    parameter int unsigned START_ADDRESS = 0,
    parameter int unsigned DEPTH_WORDS   = 256,
    parameter              INIT_FILE     = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    banked_byte_ram_if.slave bus
);
    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(START_ADDRESS) + (33'(DEPTH_WORDS) << 2);

    // Request decode
    logic [2:0]    req_size;
    logic [31:0]   req_last;
    logic          req_in_range;
    logic          req_cross;
    logic          req_err;
    logic [AW-1:0] req_word;
    logic          accept;

    // Lanes acting at the coming edge (lower word in IDLE, upper word in BEAT2)
    logic          lane_go;
    logic          lane_upper;
    logic          lane_we;
    logic [1:0]    lane_off;
    logic [2:0]    lane_size;
    logic [31:0]   lane_wdata;
    logic [AW-1:0] lane_word;

    // Accepted-command and response state
    logic          cmd_we_reg;
    logic [1:0]    cmd_off_reg;
    logic [2:0]    cmd_size_reg;
    logic          cmd_uns_reg;
    logic          rsp_valid_reg;
    logic          rsp_err_reg;
    logic [7:0]    rd_byte [4];
    logic [31:0]   rsp_word;
    logic [31:0]   rsp_ext;

`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BEAT2 = 1'b1;

    logic [0:0]    state_reg;
    logic [AW-1:0] cmd_word_reg;
    logic [31:0]   cmd_wdata_reg;

    assign bus.req_ready = (state_reg == IDLE);
`else
    assign bus.req_ready = 1'b1;
`endif

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        case (bus.req_mode)
            2'd0:    req_size = 3'd1;
            2'd1:    req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        // A last byte below the first one means the 32-bit sum wrapped.
        req_last     = bus.req_addr + 32'(req_size) - 32'd1;
        req_in_range = (req_last >= bus.req_addr) &&
                       (bus.req_addr >= START_ADDRESS) &&
                       ({1'b0, req_last} < LIMIT);
        req_cross    = ({1'b0, bus.req_addr[1:0]} + req_size) > 3'd4;
        req_word     = AW'((bus.req_addr - 32'(START_ADDRESS)) >> 2);
        req_err      = (bus.req_mode == 2'd3) || !req_in_range;
`ifndef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
        if (req_cross) req_err = 1'b1;
`endif
    end

    always_comb begin
        lane_go    = accept && !req_err;
        lane_upper = 1'b0;
        lane_we    = bus.req_we;
        lane_off   = bus.req_addr[1:0];
        lane_size  = req_size;
        lane_wdata = bus.req_wdata;
        lane_word  = req_word;
`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
        if (state_reg == BEAT2) begin
            lane_go    = 1'b1;
            lane_upper = 1'b1;
            lane_we    = cmd_we_reg;
            lane_off   = cmd_off_reg;
            lane_size  = cmd_size_reg;
            lane_wdata = cmd_wdata_reg;
            lane_word  = cmd_word_reg + AW'(1);
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_q;
            logic [2:0] rel;
            logic       hit;

            // rel is the byte index within the access that lands in this bank.
            always_comb begin
                rel = lane_upper ? (3'(gi) + 3'd4 - {1'b0, lane_off})
                                 : (3'(gi) - {1'b0, lane_off});
                hit = (lane_upper || (2'(gi) >= lane_off)) && (rel < lane_size);
            end

            always_ff @(posedge clk) begin
                if (lane_go && hit) begin
                    if (lane_we) mem[lane_word] <= lane_wdata[8*rel[1:0] +: 8];
                    else         rd_q <= mem[lane_word];
                end
            end

            assign rd_byte[gi] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            cmd_we_reg    <= 1'b0;
            cmd_off_reg   <= 2'd0;
            cmd_size_reg  <= 3'd0;
            cmd_uns_reg   <= 1'b0;
`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
            state_reg     <= IDLE;
            cmd_word_reg  <= '0;
            cmd_wdata_reg <= '0;
`endif
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            if (accept) begin
                cmd_we_reg    <= bus.req_we;
                cmd_off_reg   <= bus.req_addr[1:0];
                cmd_size_reg  <= req_size;
                cmd_uns_reg   <= bus.req_unsigned;
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= req_err;
`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
                cmd_word_reg  <= req_word;
                cmd_wdata_reg <= bus.req_wdata;
                if (!req_err && req_cross) begin
                    state_reg     <= BEAT2;
                    rsp_valid_reg <= 1'b0;
                end
`endif
            end
`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
            if (state_reg == BEAT2) begin
                state_reg     <= IDLE;
                rsp_valid_reg <= 1'b1;
            end
`endif
        end
    end

    // Byte j of the access sits in bank (offset + j) mod 4.
    always_comb begin
        rsp_word = 32'd0;
        for (int j = 0; j < 4; j++)
            rsp_word[8*j +: 8] = rd_byte[cmd_off_reg + 2'(j)];
        case (cmd_size_reg)
            3'd1:    rsp_ext = {{24{rsp_word[7]  & ~cmd_uns_reg}}, rsp_word[7:0]};
            3'd2:    rsp_ext = {{16{rsp_word[15] & ~cmd_uns_reg}}, rsp_word[15:0]};
            default: rsp_ext = rsp_word;
        endcase
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rsp_data  = (rsp_valid_reg && !rsp_err_reg && !cmd_we_reg) ? rsp_ext : 32'd0;
endmodule

// File: tb/tb_banked_byte_ram.sv
// Directed bench for banked_byte_ram (default parameters); follows BANKED_BYTE_RAM_MISALIGN_SPLIT_EN.
module tb_banked_byte_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
    localparam int XL = 2;
`else
    localparam int XL = 1;
`endif

    banked_byte_ram_if bus ();

    banked_byte_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] mode,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] data, output logic err, output int lat, output int busy);
        int waits;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_mode     = mode;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        waits = 0;
        while (!bus.req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        // Scramble the request fields once accepted; they must no longer matter.
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_addr     = ~addr;
        bus.req_mode     = 2'd3;
        bus.req_unsigned = ~uns;
        bus.req_wdata    = ~wdata;
        lat  = 1;
        busy = 0;
        while (!bus.rsp_valid && lat < 8) begin
            if (!bus.req_ready) busy++;
            @(negedge clk);
            lat++;
        end
        data = bus.rsp_data;
        err  = bus.rsp_err;
        if (!bus.rsp_valid) lat = 0;
        $display("xact we=%0d addr=0x%08h mode=%0d uns=%0d wdata=0x%08h -> data=0x%08h err=%0d lat=%0d",
                 we, addr, mode, uns, wdata, data, err, lat);
    endtask

    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] mode, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        logic [31:0] d;
        logic        e;
        int          lat;
        int          busy;
        xact(we, addr, mode, uns, wdata, d, e, lat, busy);
        check({tag, ".data"}, d, exp_data);
        check({tag, ".err"}, 32'(e), 32'(exp_err));
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy"}, 32'(busy), 32'(exp_lat - 1));
    endtask

    initial begin
        logic seen;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_mode     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'd0;

        repeat (2) @(negedge clk);
        check("rst.valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.data",  bus.rsp_data,       32'd0);
        check("rst.err",   32'(bus.rsp_err),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", 32'(bus.req_ready), 32'd1);

        // Known background for the "unchanged" checks
        run("init20",  1'b1, 32'h20,  2'd2, 1'b0, 32'h2322_2120, 32'd0, 1'b0, 1);
        run("init24",  1'b1, 32'h24,  2'd2, 1'b0, 32'h2726_2524, 32'd0, 1'b0, 1);
        run("init3c",  1'b1, 32'h3C,  2'd2, 1'b0, 32'h3F3E_3D3C, 32'd0, 1'b0, 1);
        run("init40",  1'b1, 32'h40,  2'd2, 1'b0, 32'h4342_4140, 32'd0, 1'b0, 1);
        run("init3fc", 1'b1, 32'h3FC, 2'd2, 1'b0, 32'h4433_2211, 32'd0, 1'b0, 1);

        // Aligned word, byte and halfword traffic with sign/zero extension
        run("stw10",  1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344, 32'd0,         1'b0, 1);
        run("ldw10",  1'b0, 32'h10, 2'd2, 1'b0, 32'd0,         32'h1122_3344, 1'b0, 1);
        run("ldb13s", 1'b0, 32'h13, 2'd0, 1'b0, 32'd0,         32'h0000_0011, 1'b0, 1);
        run("stb12",  1'b1, 32'h12, 2'd0, 1'b0, 32'hABCD_EFF0, 32'd0,         1'b0, 1);
        run("ldb12s", 1'b0, 32'h12, 2'd0, 1'b0, 32'd0,         32'hFFFF_FFF0, 1'b0, 1);
        run("ldb12u", 1'b0, 32'h12, 2'd0, 1'b1, 32'd0,         32'h0000_00F0, 1'b0, 1);
        run("ldw10b", 1'b0, 32'h10, 2'd2, 1'b0, 32'd0,         32'h11F0_3344, 1'b0, 1);
        run("ldh12s", 1'b0, 32'h12, 2'd1, 1'b0, 32'd0,         32'h0000_11F0, 1'b0, 1);
        run("sth14",  1'b1, 32'h14, 2'd1, 1'b0, 32'h1234_8001, 32'd0,         1'b0, 1);
        run("ldh14s", 1'b0, 32'h14, 2'd1, 1'b0, 32'd0,         32'hFFFF_8001, 1'b0, 1);
        run("ldh14u", 1'b0, 32'h14, 2'd1, 1'b1, 32'd0,         32'h0000_8001, 1'b0, 1);

        // Back-to-back store then load of the same byte, one request per cycle
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_addr     = 32'h15;
        bus.req_mode     = 2'd0;
        bus.req_unsigned = 1'b1;
        bus.req_wdata    = 32'h0000_005C;
        @(negedge clk);
        check("b2b.st_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b.st_err",   32'(bus.rsp_err),   32'd0);
        bus.req_we = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b.ld_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b.ld_data",  bus.rsp_data,       32'h0000_005C);
        @(negedge clk);
        check("b2b.pulse",    32'(bus.rsp_valid), 32'd0);
        $display("xact b2b store/load addr=0x00000015 data=0x5C");

`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
        run("stw22",  1'b1, 32'h22, 2'd2, 1'b0, 32'hAABB_CCDD, 32'd0,         1'b0, XL);
        run("ldw22",  1'b0, 32'h22, 2'd2, 1'b0, 32'd0,         32'hAABB_CCDD, 1'b0, XL);
        run("ldh23s", 1'b0, 32'h23, 2'd1, 1'b0, 32'd0,         32'hFFFF_BBCC, 1'b0, XL);
        run("ldb20",  1'b0, 32'h20, 2'd0, 1'b1, 32'd0,         32'h0000_0020, 1'b0, 1);
        run("ldb21",  1'b0, 32'h21, 2'd0, 1'b1, 32'd0,         32'h0000_0021, 1'b0, 1);
        run("ldb26",  1'b0, 32'h26, 2'd0, 1'b1, 32'd0,         32'h0000_0026, 1'b0, 1);
        run("ldw20",  1'b0, 32'h20, 2'd2, 1'b0, 32'd0,         32'hCCDD_2120, 1'b0, 1);
        run("ldw24",  1'b0, 32'h24, 2'd2, 1'b0, 32'd0,         32'h2726_AABB, 1'b0, 1);
`else
        run("stw22",  1'b1, 32'h22, 2'd2, 1'b0, 32'hAABB_CCDD, 32'd0,         1'b1, 1);
        run("ldw20",  1'b0, 32'h20, 2'd2, 1'b0, 32'd0,         32'h2322_2120, 1'b0, 1);
        run("ldw24",  1'b0, 32'h24, 2'd2, 1'b0, 32'd0,         32'h2726_2524, 1'b0, 1);
        run("ldh21u", 1'b0, 32'h21, 2'd1, 1'b1, 32'd0,         32'h0000_2221, 1'b0, 1);
        run("ldh23",  1'b0, 32'h23, 2'd1, 1'b0, 32'd0,         32'd0,         1'b1, 1);
`endif

        // Range limits, reserved mode and address wrap
        run("ldw3fc",  1'b0, 32'h3FC,       2'd2, 1'b0, 32'd0,         32'h4433_2211, 1'b0, 1);
        run("ldw3fe",  1'b0, 32'h3FE,       2'd2, 1'b0, 32'd0,         32'd0,         1'b1, 1);
        run("stw400",  1'b1, 32'h400,       2'd2, 1'b0, 32'h9999_9999, 32'd0,         1'b1, 1);
        run("ldm3",    1'b0, 32'h3FC,       2'd3, 1'b0, 32'd0,         32'd0,         1'b1, 1);
        run("stm3",    1'b1, 32'h3FC,       2'd3, 1'b0, 32'hDEAD_BEEF, 32'd0,         1'b1, 1);
        run("ldhwrap", 1'b0, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'd0,         32'd0,         1'b1, 1);
        run("ldw3fc2", 1'b0, 32'h3FC,       2'd2, 1'b0, 32'd0,         32'h4433_2211, 1'b0, 1);
        run("stb3ff",  1'b1, 32'h3FF,       2'd0, 1'b0, 32'h0000_0099, 32'd0,         1'b0, 1);
        run("ldw3fc3", 1'b0, 32'h3FC,       2'd2, 1'b0, 32'd0,         32'h9933_2211, 1'b0, 1);

`ifdef BANKED_BYTE_RAM_MISALIGN_SPLIT_EN
        // Reset landing in BEAT2 of a crossing store
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_addr     = 32'h3E;
        bus.req_mode     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h5566_7788;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstb2.busy", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstb2.valid", 32'(bus.rsp_valid), 32'd0);
        check("rstb2.ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("rstb2.norsp", 32'(seen),          32'd0);
        check("rstb2.after", 32'(bus.req_ready), 32'd1);
        $display("xact reset in BEAT2 of store addr=0x0000003e");
        run("ldw3c", 1'b0, 32'h3C, 2'd2, 1'b0, 32'd0, 32'h7788_3D3C, 1'b0, 1);
        run("ldw40", 1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 32'h4342_4140, 1'b0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
